// File: rtl/fb_avl_port.sv
// Frame-buffer port between a pixel controller and an Avalon-MM DDR controller.
// Optional FB_TEST_PATTERN_EN: write the word address as data instead of wr_data.
module fb_avl_port #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 25,
    parameter int unsigned FRAME_WORDS     = 307200,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  avl_ready,
    output logic                  full,
    output logic                  rd_done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    input  logic                  avl_waitrequest_n,
    output logic [ADDR_WIDTH-1:0] avl_address,
    output logic                  avl_write_req,
    output logic                  avl_read_req,
    output logic [DATA_WIDTH-1:0] avl_wdata,
    input  logic [DATA_WIDTH-1:0] avl_rdata,
    input  logic                  avl_rdata_valid,
    output logic [2:0]            avl_size
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
    localparam logic [3:0]            MaxOut   = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {s_idle, s_write, s_read, s_drain} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, rd_addr_q, ret_cnt_q;
    logic [3:0]              outstanding_q;
    logic                    full_q, rd_done_q, rd_data_valid_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    at_limit, wr_accept, rd_accept, rd_return;

    assign at_limit  = (outstanding_q >= MaxOut);
    assign wr_accept = avl_write_req & avl_waitrequest_n;
    assign rd_accept = avl_read_req & avl_waitrequest_n;
    // Returns with nothing in flight are stale (e.g. issued before a reset).
    assign rd_return = avl_rdata_valid & (outstanding_q != 4'd0);

    always_comb begin
        state_d       = state_q;
        avl_write_req = 1'b0;
        avl_read_req  = 1'b0;
        avl_address   = '0;
        avl_ready     = avl_waitrequest_n;
        unique case (state_q)
            s_idle: begin
                if (!wr_en) begin
                    state_d       = s_write;
                    avl_write_req = 1'b1;
                    avl_address   = wr_addr_q;
                end else if (!rd_en) begin
                    state_d = s_read;
                end
            end
            s_write: begin
                avl_write_req = ~wr_en;
                avl_address   = wr_addr_q;
                if (wr_en) state_d = rd_en ? s_idle : s_drain;
            end
            s_read: begin
                avl_read_req = ~rd_en & ~at_limit;
                avl_address  = rd_addr_q;
                if (at_limit) avl_ready = 1'b0;
                if (rd_en) state_d = s_drain;
            end
            s_drain: begin
                avl_ready = 1'b0;
                if (outstanding_q == 4'd0) state_d = s_idle;
            end
            default: state_d = s_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= s_idle;
            wr_addr_q       <= '0;
            rd_addr_q       <= '0;
            ret_cnt_q       <= '0;
            outstanding_q   <= 4'd0;
            full_q          <= 1'b0;
            rd_done_q       <= 1'b0;
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            state_q <= state_d;
            if (wr_accept) wr_addr_q <= (wr_addr_q == LastAddr) ? '0 : wr_addr_q + AddrOne;
            full_q <= wr_accept && (wr_addr_q == LastAddr);
            if (rd_accept) rd_addr_q <= (rd_addr_q == LastAddr) ? '0 : rd_addr_q + AddrOne;
            if (rd_return) ret_cnt_q <= (ret_cnt_q == LastAddr) ? '0 : ret_cnt_q + AddrOne;
            rd_done_q <= rd_return && (ret_cnt_q == LastAddr);
            case ({rd_accept, rd_return})
                2'b10:   outstanding_q <= outstanding_q + 4'd1;
                2'b01:   outstanding_q <= outstanding_q - 4'd1;
                default: outstanding_q <= outstanding_q;
            endcase
            rd_data_valid_q <= rd_return;
            rd_data_q       <= avl_rdata;
        end
    end

`ifdef FB_TEST_PATTERN_EN
    assign avl_wdata = DATA_WIDTH'(wr_addr_q);
`else
    assign avl_wdata = wr_data;
`endif

    assign full          = full_q;
    assign rd_done       = rd_done_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
    assign avl_size      = 3'd1;

endmodule

// File: tb/tb_fb_avl_port.sv
// Randomized bench for fb_avl_port: an in-order fixed-latency memory plus a
// frame-level model (address counters, in-flight FIFO) checked every cycle.
module tb_fb_avl_port;

    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int FW   = 16;
    localparam int MAXO = 4;
    localparam int LAT  = 8;

    logic          clk, reset, wr_en, rd_en;
    logic [DW-1:0] wr_data, rd_data, avl_wdata, avl_rdata;
    logic          avl_ready, full, rd_done, rd_data_valid;
    logic          avl_waitrequest_n, avl_write_req, avl_read_req, avl_rdata_valid;
    logic [AW-1:0] avl_address;
    logic [2:0]    avl_size;

    fb_avl_port #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .FRAME_WORDS    (FW),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_en            (wr_en),
        .rd_en            (rd_en),
        .wr_data          (wr_data),
        .avl_ready        (avl_ready),
        .full             (full),
        .rd_done          (rd_done),
        .rd_data          (rd_data),
        .rd_data_valid    (rd_data_valid),
        .avl_waitrequest_n(avl_waitrequest_n),
        .avl_address      (avl_address),
        .avl_write_req    (avl_write_req),
        .avl_read_req     (avl_read_req),
        .avl_wdata        (avl_wdata),
        .avl_rdata        (avl_rdata),
        .avl_rdata_valid  (avl_rdata_valid),
        .avl_size         (avl_size)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {int due; int addr;} rsp_t;

    int            n_checks = 0, n_errors = 0;
    int            cyc = 0;
    logic [DW-1:0] mem [FW];
    rsp_t          mem_q[$];
    int            rd_fifo[$];
    bit            inject = 0;

    // Frame-level model
    int            wr_ptr = 0, rd_ptr = 0, ret_idx = 0, mdl_out = 0, max_out = 0;
    bit            exp_full = 0, exp_rdv = 0, exp_done = 0, exp_rd_zero = 0;
    logic [DW-1:0] exp_rdata = '0;
    int            n_wr = 0, n_full = 0, n_ret = 0, n_done = 0;
    bit            ready_low_seen = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        bit wa, ra, ret;
        logic [DW-1:0] exp_wdata;
        check_eq("full", full, exp_full);
        check_eq("rd_data_valid", rd_data_valid, exp_rdv);
        check_eq("rd_done", rd_done, exp_done);
        if (exp_rdv) check_eq("rd_data", rd_data, exp_rdata);
        if (exp_rd_zero) check_eq("rd_data_reset", rd_data, 0);
        check_eq("req_mutex", avl_write_req & avl_read_req, 0);
        if (avl_write_req) begin
`ifdef FB_TEST_PATTERN_EN
            exp_wdata = DW'(wr_ptr);
`else
            exp_wdata = wr_data;
`endif
            check_eq("wr_address", avl_address, wr_ptr);
            check_eq("wdata", avl_wdata, exp_wdata);
            check_eq("ready_wr", avl_ready, avl_waitrequest_n);
        end
        if (avl_read_req) check_eq("rd_address", avl_address, rd_ptr);
        if (mdl_out == MAXO) begin
            check_eq("ready_at_limit", avl_ready, 0);
            check_eq("rd_req_at_limit", avl_read_req, 0);
            ready_low_seen = 1;
        end
        if (full) n_full++;
        if (rd_data_valid) n_ret++;
        if (rd_done) n_done++;

        if (!reset) begin
            wr_ptr = 0; rd_ptr = 0; ret_idx = 0; mdl_out = 0;
            rd_fifo.delete();
            exp_full = 0; exp_rdv = 0; exp_done = 0; exp_rd_zero = 1;
        end else begin
            wa = avl_write_req && avl_waitrequest_n;
            ra = avl_read_req && avl_waitrequest_n;
            ret = avl_rdata_valid && (mdl_out > 0);
            exp_full = wa && (wr_ptr == FW - 1);
            if (wa) begin
                wr_ptr = (wr_ptr + 1) % FW;
                n_wr++;
            end
            if (ra) begin
                rd_fifo.push_back(rd_ptr);
                mem_q.push_back('{due: cyc + LAT, addr: rd_ptr});
                rd_ptr = (rd_ptr + 1) % FW;
            end
            exp_rdv  = ret;
            exp_done = ret && (ret_idx == FW - 1);
            if (ret) begin
                exp_rdata = mem[rd_fifo.pop_front()];
                ret_idx   = (ret_idx + 1) % FW;
            end
            mdl_out = mdl_out + int'(ra) - int'(ret);
            if (mdl_out > max_out) max_out = mdl_out;
            exp_rd_zero = 0;
        end
    endtask

    task automatic drive_mem();
        avl_rdata_valid = 1'b0;
        avl_rdata       = $urandom;
        if (inject) begin
            avl_rdata_valid = 1'b1;
            inject          = 0;
        end else if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            avl_rdata_valid = 1'b1;
            avl_rdata       = mem[mem_q[0].addr];
            void'(mem_q.pop_front());
        end
    endtask

    task automatic sample();
        #3;
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        drive_mem();
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while (mdl_out != 0 && i < 80) begin
            tick();
            i++;
        end
        check_eq(tag, mdl_out, 0);
        repeat (2) tick();
    endtask

    initial begin
        int n0, f0, r0, d0, got;
        logic [AW-1:0] hold_addr;
        logic [DW-1:0] hold_wdata;
        for (int i = 0; i < FW; i++) mem[i] = $urandom;
        reset = 1'b0; wr_en = 1'b1; rd_en = 1'b1; wr_data = '0;
        avl_waitrequest_n = 1'b1; avl_rdata = '0; avl_rdata_valid = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        reset = 1'b1;

        // Reset state
        sample();
        check_eq("rst_write_req", avl_write_req, 0);
        check_eq("rst_read_req", avl_read_req, 0);
        check_eq("rst_ready", avl_ready, 1);
        check_eq("avl_size", avl_size, 1);
        advance();

        // One full frame of back-to-back writes
        n0 = n_wr; f0 = n_full;
        wr_en = 1'b0;
        for (int i = 0; i < FW; i++) begin
`ifdef FB_TEST_PATTERN_EN
            wr_data = '1;
`else
            wr_data = $urandom;
`endif
            tick();
        end
        wr_en = 1'b1;
        tick();
        check_eq("frame_writes", n_wr - n0, FW);
        check_eq("full_once", n_full - f0, 1);

        // Waitrequest stall holds the command
        n0 = n_wr;
        wr_en = 1'b0; wr_data = $urandom; avl_waitrequest_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (i == 0) begin
                hold_addr  = avl_address;
                hold_wdata = avl_wdata;
            end
            check_eq("stall_addr", avl_address, hold_addr);
            check_eq("stall_wdata", avl_wdata, hold_wdata);
            check_eq("stall_ready", avl_ready, 0);
            advance();
        end
        check_eq("stall_no_advance", n_wr - n0, 0);
        avl_waitrequest_n = 1'b1;
        tick();
        check_eq("stall_release", n_wr - n0, 1);
        wr_en = 1'b1;
        tick();

        // Frame read against latency-8 memory
        r0 = n_ret; d0 = n_done; max_out = 0; ready_low_seen = 0;
        rd_en = 1'b0;
        for (int i = 0; i < 300 && (n_ret - r0) < FW; i++) tick();
        rd_en = 1'b1;
        check_eq("rd_beats", n_ret - r0, FW);
        check_eq("rd_done_once", n_done - d0, 1);
        check_eq("max_outstanding", max_out, MAXO);
        check_eq("ready_low_at_limit", ready_low_seen, 1);
        drain("read_drain");

        // Drain blocks a pending write
        rd_en = 1'b0;
        for (int i = 0; i < 20 && mdl_out != 3; i++) tick();
        check_eq("three_in_flight", mdl_out, 3);
        rd_en = 1'b1; wr_en = 1'b0; wr_data = $urandom;
        for (int i = 0; i < 40 && mdl_out != 0; i++) begin
            sample();
            check_eq("no_wr_in_drain", avl_write_req, 0);
            advance();
        end
        got = 0;
        for (int i = 0; i < 4 && got == 0; i++) begin
            sample();
            if (avl_write_req) got = 1;
            advance();
        end
        check_eq("wr_after_drain", got, 1);
        wr_en = 1'b1;
        tick();

        // Stale return with nothing outstanding
        r0 = n_ret;
        inject = 1;
        repeat (3) tick();
        check_eq("stale_discard", n_ret - r0, 0);

        // Reset mid-frame, then a clean frame
        reset = 1'b0; tick(); reset = 1'b1;
        wr_en = 1'b0;
        repeat (10) begin wr_data = $urandom; tick(); end
        wr_en = 1'b1; reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        f0 = n_full;
        wr_en = 1'b0;
        for (int i = 0; i < FW; i++) begin
            wr_data = $urandom;
            sample();
            if (i == 0) check_eq("addr_after_reset", avl_address, 0);
            advance();
        end
        wr_en = 1'b1;
        check_eq("no_early_full", n_full - f0, 0);
        tick();
        check_eq("full_after_16", n_full - f0, 1);

        // Reset with reads in flight
        rd_en = 1'b0;
        repeat (5) tick();
        rd_en = 1'b1; reset = 1'b0;
        tick();
        reset = 1'b1;
        r0 = n_ret; d0 = n_done;
        repeat (12) tick();
        check_eq("inflight_discard", n_ret - r0, 0);
        check_eq("no_done_after_reset", n_done - d0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) wr_en = ~wr_en;
            if ($urandom_range(0, 7) == 0) rd_en = ~rd_en;
            avl_waitrequest_n = ($urandom_range(0, 4) != 0);
            wr_data = $urandom;
            tick();
        end
        wr_en = 1'b1; rd_en = 1'b1; avl_waitrequest_n = 1'b1;
        drain("random_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
